// File: rtl/rf_read_sequencer.sv
// rtl/rf_read_sequencer.sv - sequences two ID operand reads onto a single-port register RAM
module rf_read_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic                      id_read_en_1,
   input  logic                      id_read_en_2,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_1,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_2,
   output logic [DATA_WIDTH-1:0]     id_data_1,
   output logic [DATA_WIDTH-1:0]     id_data_2,
   output logic                      id_data_valid,
   output logic                      stall_req,
   output logic                      ram_read_en,
   output logic [REG_ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0]     ram_data,
   input  logic                      wb_write_en,
   input  logic [REG_ADDR_WIDTH-1:0] wb_write_addr,
   input  logic [DATA_WIDTH-1:0]     wb_write_data
);

   typedef enum logic [1:0] {IDLE, RD1, RD2, DONE} state_t;

   state_t                    state_q;
   state_t                    state_d;

   logic                      need_1;
   logic                      need_2;
   logic                      dup;
   logic                      wb_hit_1;
   logic                      wb_hit_2;
   logic                      cap_1;
   logic                      cap_2;
   logic                      busy;
   logic                      rd_en_c;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_c;

   logic [DATA_WIDTH-1:0]     data_1_q;
   logic [DATA_WIDTH-1:0]     data_2_q;
   // Set once a writeback newer than the RAM read has been folded into the data register.
   logic                      byp_1_q;
   logic                      byp_2_q;

   // Register 0 and disabled ports never touch the RAM; both read as 0.
   assign need_1 = id_read_en_1 && (id_addr_1 != '0);
   assign need_2 = id_read_en_2 && (id_addr_2 != '0);
   assign dup    = need_1 && need_2 && (id_addr_1 == id_addr_2);

   // need_k already excludes address 0, so writes to r0 never bypass.
   assign wb_hit_1 = need_1 && wb_write_en && (wb_write_addr == id_addr_1);
   assign wb_hit_2 = need_2 && wb_write_en && (wb_write_addr == id_addr_2);

   // RAM data for a port arrives in the state after its issue cycle.
   assign cap_1 = (state_q == RD1);
   assign cap_2 = ((state_q == RD1) && dup) || (state_q == RD2);
   assign busy  = (state_q == RD1) || (state_q == RD2);

   // State register; reset and flushes both land in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and RAM read issue; at most one read per cycle.
   always_comb begin
      state_d   = state_q;
      rd_en_c   = 1'b0;
      rd_addr_c = '0;
      case (state_q)
         IDLE: begin
            if (id_valid) begin
               if (need_1) begin
                  rd_en_c   = 1'b1;
                  rd_addr_c = id_addr_1;
                  state_d   = RD1;
               end else if (need_2) begin
                  rd_en_c   = 1'b1;
                  rd_addr_c = id_addr_2;
                  state_d   = RD2;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD1: begin
            if (!id_valid) begin
               state_d = IDLE;
            end else if (need_2 && !dup) begin
               rd_en_c   = 1'b1;
               rd_addr_c = id_addr_2;
               state_d   = RD2;
            end else begin
               state_d = DONE;
            end
         end
         RD2: begin
            if (!id_valid) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ram_read_en = rd_en_c && !rst;
   assign ram_addr    = ram_read_en ? rd_addr_c : '0;

   // Operand holding registers: cleared on accept, then RAM capture or writeback bypass.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_1_q <= '0;
         data_2_q <= '0;
         byp_1_q  <= 1'b0;
         byp_2_q  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (id_valid) begin
            data_1_q <= wb_hit_1 ? wb_write_data : '0;
            data_2_q <= wb_hit_2 ? wb_write_data : '0;
            byp_1_q  <= wb_hit_1;
            byp_2_q  <= wb_hit_2;
         end
      end else if (busy && id_valid) begin
         if (wb_hit_1) begin
            data_1_q <= wb_write_data;
            byp_1_q  <= 1'b1;
         end else if (cap_1 && !byp_1_q) begin
            data_1_q <= ram_data;
         end
         if (wb_hit_2) begin
            data_2_q <= wb_write_data;
            byp_2_q  <= 1'b1;
         end else if (cap_2 && !byp_2_q) begin
            data_2_q <= ram_data;
         end
      end
   end

   assign id_data_valid = !rst && id_valid && (state_q == DONE);
   assign stall_req     = !rst && id_valid && !id_data_valid;

   // A write landing in DONE is forwarded straight through to ID.
   assign id_data_1 = (state_q == IDLE)                ? '0 :
                      ((state_q == DONE) && wb_hit_1)  ? wb_write_data : data_1_q;
   assign id_data_2 = (state_q == IDLE)                ? '0 :
                      ((state_q == DONE) && wb_hit_2)  ? wb_write_data : data_2_q;

endmodule
